// File: rtl/candidate_collector.sv
// Purpose : buffers the window coordinates of every positive classifier verdict and streams them out, followed by one per-frame summary record.
// Latency : 1 cycle from inspect_done to o_valid, because the FIFO is first-word fall-through.
// Backpressure: out_ready low holds the head record stable; a candidate that arrives with the FIFO full and no pop is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk_fpga, reset_fpga_n     : clock, asynchronous active-low reset (release is resynchronised internally)
//   frame_start, frame_end     : frame boundary pulses
//   inspect_done, candidate    : classifier verdict strobe and result
//   resize_x, resize_y         : window coordinates, sampled with inspect_done
//   out_ready / o_valid        : output handshake
//   o_x, o_y, o_last           : record payload; the summary record carries {count, overflow}
//   o_overflow, o_busy         : sticky drop flag, FSM-not-idle
// Optional feature: `define CANDIDATE_MERGE_EN suppresses candidates within MERGE_DIST of the last accepted one.
module candidate_collector #(
    parameter int DATA_WIDTH_12 = 12,
    parameter int FIFO_DEPTH    = 16,
    parameter int MERGE_DIST    = 2
) (
    input  logic                     clk_fpga,
    input  logic                     reset_fpga_n,
    input  logic                     frame_start,
    input  logic                     frame_end,
    input  logic                     inspect_done,
    input  logic                     candidate,
    input  logic [DATA_WIDTH_12-1:0] resize_x,
    input  logic [DATA_WIDTH_12-1:0] resize_y,
    input  logic                     out_ready,
    output logic                     o_valid,
    output logic [DATA_WIDTH_12-1:0] o_x,
    output logic [DATA_WIDTH_12-1:0] o_y,
    output logic                     o_last,
    output logic                     o_overflow,
    output logic                     o_busy
);

    localparam int W  = DATA_WIDTH_12;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [W-1:0]  CNT_MAX = '1;
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, SUMMARY} state_t;

    // Reset asserts immediately and releases on a clock edge, so every flop
    // leaves reset in the same cycle.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk_fpga or negedge reset_fpga_n) begin
        if (!reset_fpga_n) rst_sync <= 2'b00;
        else               rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    state_t          state;
    logic [2*W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     occ;
    logic [W-1:0]    count;
    logic            overflow;

    logic fifo_empty, fifo_full, stream_vld, pop;
    logic push_req, push, drop, merge_hit;

    assign fifo_empty = (occ == '0);
    assign fifo_full  = (occ == OCC_FULL);
    assign stream_vld = ((state == COLLECT) || (state == DRAIN)) && !fifo_empty;
    assign pop        = stream_vld && out_ready;

    // frame_start wins over a same-cycle verdict, so the flushed FIFO does
    // not receive a leftover entry from the abandoned frame.
    assign push_req = (state == COLLECT) && inspect_done && candidate && !frame_start && !merge_hit;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

`ifdef CANDIDATE_MERGE_EN
    localparam logic [W-1:0] MERGE_LIM = W'(MERGE_DIST);

    logic [W-1:0] last_x, last_y;
    logic         last_vld;

    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign merge_hit = last_vld
                    && (abs_diff(resize_x, last_x) <= MERGE_LIM)
                    && (abs_diff(resize_y, last_y) <= MERGE_LIM);

    // Reference coordinate follows accepted pushes only; dropped or merged
    // candidates never become the reference.
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            last_x   <= '0;
            last_y   <= '0;
            last_vld <= 1'b0;
        end else if (frame_start) begin
            last_vld <= 1'b0;
        end else if (push) begin
            last_x   <= resize_x;
            last_y   <= resize_y;
            last_vld <= 1'b1;
        end
    end
`else
    logic unused_merge_dist;
    assign unused_merge_dist = ^MERGE_DIST;
    assign merge_hit = 1'b0;
`endif

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_fpga) begin
        if (push) mem[wr_ptr] <= {resize_x, resize_y};
    end

    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (frame_start) begin
            // Restart from any state; an in-flight record is abandoned.
            state    <= COLLECT;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (push && (count != CNT_MAX)) count <= count + 1'b1;
            if (drop) overflow <= 1'b1;

            case (state)
                IDLE:    state <= IDLE;
                COLLECT: if (frame_end) state <= DRAIN;
                DRAIN:   if (fifo_empty) state <= SUMMARY;
                SUMMARY: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Payload is forced to zero whenever no record is offered.
    always_comb begin
        o_x = '0;
        o_y = '0;
        if (state == SUMMARY) begin
            o_x = count;
            o_y = {{(W-1){1'b0}}, overflow};
        end else if (stream_vld) begin
            o_x = mem[rd_ptr][2*W-1:W];
            o_y = mem[rd_ptr][W-1:0];
        end
    end

    assign o_valid    = stream_vld || (state == SUMMARY);
    assign o_last     = (state == SUMMARY);
    assign o_overflow = overflow;
    assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_candidate_collector.sv
module tb_candidate_collector;

    logic        clk_fpga = 1'b0;
    logic        reset_fpga_n;
    logic        frame_start, frame_end, inspect_done, candidate, out_ready;
    logic [11:0] resize_x, resize_y;
    logic        o_valid, o_last, o_overflow, o_busy;
    logic [11:0] o_x, o_y;

    always #5 clk_fpga = ~clk_fpga;

    candidate_collector #(
        .DATA_WIDTH_12 (12),
        .FIFO_DEPTH    (16),
        .MERGE_DIST    (2)
    ) dut (
        .clk_fpga     (clk_fpga),
        .reset_fpga_n (reset_fpga_n),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .inspect_done (inspect_done),
        .candidate    (candidate),
        .resize_x     (resize_x),
        .resize_y     (resize_y),
        .out_ready    (out_ready),
        .o_valid      (o_valid),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_last       (o_last),
        .o_overflow   (o_overflow),
        .o_busy       (o_busy)
    );

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        last;
    } rec_t;

    rec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge whenever
    // o_valid && out_ready is seen at the falling edge.
    always @(negedge clk_fpga) begin
        rec_t e;
        if (reset_fpga_n && o_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_record: got x=%0d y=%0d last=%0d, expected no record", o_x, o_y, o_last);
            end else begin
                e = exp_q.pop_front();
                check("rec_x", o_x, e.x);
                check("rec_y", o_y, e.y);
                check("rec_last", o_last, e.last);
            end
        end
    end

    task automatic tick();
        @(posedge clk_fpga);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_end();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic inspect(input logic [11:0] x, input logic [11:0] y);
        inspect_done = 1'b1;
        candidate    = 1'b1;
        resize_x     = x;
        resize_y     = y;
        tick();
        inspect_done = 1'b0;
        candidate    = 1'b0;
    endtask

    task automatic expect_rec(input logic [11:0] x, input logic [11:0] y, input logic last);
        rec_t r;
        r.x = x;
        r.y = y;
        r.last = last;
        exp_q.push_back(r);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_fpga);
            if (!o_busy && exp_q.size() == 0) break;
        end
        check({name, "_idle"}, o_busy, 0);
        check({name, "_drained"}, exp_q.size(), 0);
        tick();
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_valid"}, o_valid, 0);
        check({name, "_x"}, o_x, 0);
        check({name, "_y"}, o_y, 0);
        check({name, "_last"}, o_last, 0);
        check({name, "_ovf"}, o_overflow, 0);
        check({name, "_busy"}, o_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_fpga_n = 1'b0;
        frame_start  = 1'b0;
        frame_end    = 1'b0;
        inspect_done = 1'b0;
        candidate    = 1'b0;
        resize_x     = '0;
        resize_y     = '0;
        out_ready    = 1'b0;
        repeat (3) tick();
        check_outputs_zero("por");
        reset_fpga_n = 1'b1;
        repeat (3) tick();

        // Reset mid-frame with three entries queued, plus first-push latency.
        pulse_start();
        check("latency_pre_valid", o_valid, 0);
        inspect(12'd1, 12'd2);
        check("latency_post_valid", o_valid, 1);
        check("latency_post_x", o_x, 1);
        inspect(12'd3, 12'd4);
        inspect(12'd5, 12'd6);
        check("midframe_busy", o_busy, 1);
        reset_fpga_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        tick();
        reset_fpga_n = 1'b1;
        repeat (3) tick();
        check("postrst_busy", o_busy, 0);
        check("postrst_valid", o_valid, 0);

        // Three candidates streamed with ready held high.
        out_ready = 1'b1;
        expect_rec(12'd4, 12'd5, 1'b0);
        expect_rec(12'd9, 12'd1, 1'b0);
        expect_rec(12'd20, 12'd7, 1'b0);
        expect_rec(12'd3, 12'd0, 1'b1);
        pulse_start();
        inspect(12'd4, 12'd5);
        inspect(12'd9, 12'd1);
        inspect(12'd20, 12'd7);
        pulse_end();
        wait_idle("basic");

        // Overflow: 20 candidates into 16 entries with ready low, then a stall hold check.
        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            if (i < 16) expect_rec(12'(i), 12'(100 + i), 1'b0);
            inspect(12'(i), 12'(100 + i));
        end
        check("ovf_set", o_overflow, 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", o_valid, 1);
            check("stall_x", o_x, 0);
            check("stall_y", o_y, 100);
            check("stall_last", o_last, 0);
            tick();
        end
        expect_rec(12'd16, 12'd1, 1'b1);
        out_ready = 1'b1;
        pulse_end();
        wait_idle("ovf");
        check("ovf_sticky", o_overflow, 1);

        // Full FIFO with pop and push in the same cycle.
        out_ready = 1'b0;
        pulse_start();
        check("ovf_cleared", o_overflow, 0);
        for (int i = 0; i < 16; i++) begin
            expect_rec(12'(50 + i), 12'(i), 1'b0);
            inspect(12'(50 + i), 12'(i));
        end
        check("full_no_ovf", o_overflow, 0);
        expect_rec(12'd200, 12'd201, 1'b0);
        out_ready = 1'b1;
        inspect(12'd200, 12'd201);
        out_ready = 1'b0;
        check("poppush_no_ovf", o_overflow, 0);
        expect_rec(12'd17, 12'd0, 1'b1);
        out_ready = 1'b1;
        pulse_end();
        wait_idle("poppush");

        // Near-duplicate candidates.
        out_ready = 1'b1;
`ifdef CANDIDATE_MERGE_EN
        expect_rec(12'd10, 12'd10, 1'b0);
        expect_rec(12'd13, 12'd10, 1'b0);
        expect_rec(12'd2, 12'd0, 1'b1);
`else
        expect_rec(12'd10, 12'd10, 1'b0);
        expect_rec(12'd11, 12'd12, 1'b0);
        expect_rec(12'd13, 12'd10, 1'b0);
        expect_rec(12'd3, 12'd0, 1'b1);
`endif
        pulse_start();
        inspect(12'd10, 12'd10);
        inspect(12'd11, 12'd12);
        inspect(12'd13, 12'd10);
        pulse_end();
        wait_idle("merge");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
